// File: rtl/flash_loader.sv
// flash_loader
//
// Boot-time copier from SPI NOR flash into the cache word-write port.
// Selects the flash after a start-up delay, sends READ (0x03) plus a 24-bit
// address, then streams bytes back. Every four bytes are packed little-endian
// into one 32-bit word and written to the cache. When the configured number of
// bytes has been written the flash is released and done is raised.
//
// Ports
//   clk                 cache-domain clock
//   rst                 asynchronous, active-high reset
//   flash_clk           SPI clock (mode 0, clk/2)
//   flash_mosi          SPI data to flash
//   flash_miso          SPI data from flash
//   flash_cs            flash chip select, active low
//   cache_address       byte address of the current word write
//   cache_data_in       word being written
//   cache_write_enable  byte enables, 4'b1111 for the single write cycle
//   cache_busy          cache cannot accept a command while high
//   done                transfer complete, sticky until reset
//
// state      | meaning
// -----------+-----------------------------------------------------------
// STARTUP    | idle after reset, counting STARTUP_WAIT cycles
// SEND       | shifting out command byte and 24-bit address, MSB first
// READ       | clocking in 32 data bits, packing bytes into the word
// WRITE      | presenting the word to the cache, held while cache is busy
// WAIT_CACHE | one skip cycle, then waiting for the cache to go idle
// DONE       | flash released, done high until reset

module flash_loader #(
   parameter int unsigned STARTUP_WAIT       = 1_000_000,
   parameter logic [23:0] FLASH_ADDRESS      = 24'h00_0000,
   parameter logic [31:0] CACHE_ADDRESS      = 32'h0000_0000,
   parameter logic [31:0] TRANSFER_BYTES_NUM = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        flash_clk,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic        flash_cs,
   output logic [31:0] cache_address,
   output logic [31:0] cache_data_in,
   output logic [3:0]  cache_write_enable,
   input  logic        cache_busy,
   output logic        done
);

   if (TRANSFER_BYTES_NUM == 32'd0 || TRANSFER_BYTES_NUM[1:0] != 2'b00) begin : g_bad_size
      $error("flash_loader: TRANSFER_BYTES_NUM must be a nonzero multiple of 4");
   end

   localparam logic [31:0] WAIT_LAST = 32'(STARTUP_WAIT - 1);
   localparam logic [7:0]  CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      STARTUP,
      SEND,
      READ,
      WRITE,
      WAIT_CACHE,
      DONE
   } state_t;

   state_t      state, state_next;
   logic [31:0] startup_cnt, startup_cnt_next;
   logic [31:0] shift_reg, shift_reg_next;
   logic [4:0]  bit_cnt, bit_cnt_next;
   logic        phase, phase_next;
   logic [6:0]  byte_sr, byte_sr_next;
   logic [31:0] word_reg, word_reg_next;
   logic [31:0] addr_reg, addr_reg_next;
   logic [31:0] byte_cnt, byte_cnt_next;
   logic        skip, skip_next;
   logic        cs_reg, cs_next;
   logic        sclk_reg, sclk_next;
   logic        mosi_reg, mosi_next;
   logic        done_reg, done_next;
   logic [3:0]  we_comb;
   logic [7:0]  byte_full;

   // Bits 6:0 of the byte arrive first; the bit sampled this cycle completes it.
   assign byte_full = {byte_sr, flash_miso};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= STARTUP;
         startup_cnt <= 32'd0;
         shift_reg   <= 32'd0;
         bit_cnt     <= 5'd0;
         phase       <= 1'b0;
         byte_sr     <= 7'd0;
         word_reg    <= 32'd0;
         addr_reg    <= CACHE_ADDRESS;
         byte_cnt    <= 32'd0;
         skip        <= 1'b0;
         cs_reg      <= 1'b1;
         sclk_reg    <= 1'b0;
         mosi_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state       <= state_next;
         startup_cnt <= startup_cnt_next;
         shift_reg   <= shift_reg_next;
         bit_cnt     <= bit_cnt_next;
         phase       <= phase_next;
         byte_sr     <= byte_sr_next;
         word_reg    <= word_reg_next;
         addr_reg    <= addr_reg_next;
         byte_cnt    <= byte_cnt_next;
         skip        <= skip_next;
         cs_reg      <= cs_next;
         sclk_reg    <= sclk_next;
         mosi_reg    <= mosi_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next       = state;
      startup_cnt_next = startup_cnt;
      shift_reg_next   = shift_reg;
      bit_cnt_next     = bit_cnt;
      phase_next       = phase;
      byte_sr_next     = byte_sr;
      word_reg_next    = word_reg;
      addr_reg_next    = addr_reg;
      byte_cnt_next    = byte_cnt;
      skip_next        = skip;
      cs_next          = cs_reg;
      sclk_next        = sclk_reg;
      mosi_next        = mosi_reg;
      done_next        = done_reg;
      we_comb          = 4'b0000;

      case (state)
         STARTUP: begin
            if (startup_cnt == WAIT_LAST) begin
               state_next     = SEND;
               cs_next        = 1'b0;
               shift_reg_next = {CMD_READ, FLASH_ADDRESS};
               bit_cnt_next   = 5'd0;
               phase_next     = 1'b0;
            end else begin
               startup_cnt_next = startup_cnt + 32'd1;
            end
         end

         SEND: begin
            if (!phase) begin
               sclk_next  = 1'b0;
               mosi_next  = shift_reg[31];
               phase_next = 1'b1;
            end else begin
               sclk_next      = 1'b1;
               phase_next     = 1'b0;
               shift_reg_next = {shift_reg[30:0], 1'b0};
               // 5-bit counter wraps to 0 after the 32nd bit, ready for READ.
               bit_cnt_next   = bit_cnt + 5'd1;
               if (bit_cnt == 5'd31) begin
                  state_next = READ;
               end
            end
         end

         READ: begin
            if (!phase) begin
               sclk_next  = 1'b0;
               mosi_next  = 1'b0;
               phase_next = 1'b1;
            end else begin
               sclk_next    = 1'b1;
               phase_next   = 1'b0;
               byte_sr_next = {byte_sr[5:0], flash_miso};
               if (bit_cnt[2:0] == 3'd7) begin
                  case (bit_cnt[4:3])
                     2'd0:    word_reg_next[7:0]   = byte_full;
                     2'd1:    word_reg_next[15:8]  = byte_full;
                     2'd2:    word_reg_next[23:16] = byte_full;
                     default: word_reg_next[31:24] = byte_full;
                  endcase
               end
               bit_cnt_next = bit_cnt + 5'd1;
               if (bit_cnt == 5'd31) begin
                  state_next = WRITE;
               end
            end
         end

         WRITE: begin
            sclk_next = 1'b0;
            // Enable is gated by busy in the same cycle so a write is never
            // presented while the cache reports busy.
            if (!cache_busy) begin
               we_comb    = 4'b1111;
               state_next = WAIT_CACHE;
               skip_next  = 1'b1;
            end
         end

         WAIT_CACHE: begin
            sclk_next = 1'b0;
            if (skip) begin
               skip_next = 1'b0;
            end else if (!cache_busy) begin
               addr_reg_next = addr_reg + 32'd4;
               byte_cnt_next = byte_cnt + 32'd4;
               if (byte_cnt + 32'd4 == TRANSFER_BYTES_NUM) begin
                  state_next = DONE;
                  cs_next    = 1'b1;
                  done_next  = 1'b1;
               end else begin
                  state_next = READ;
               end
            end
         end

         DONE: begin
            cs_next   = 1'b1;
            sclk_next = 1'b0;
            mosi_next = 1'b0;
            done_next = 1'b1;
         end

         default: begin
            state_next = STARTUP;
         end
      endcase
   end

   assign flash_cs           = cs_reg;
   assign flash_clk          = sclk_reg;
   assign flash_mosi         = mosi_reg;
   assign cache_address      = addr_reg;
   assign cache_data_in      = word_reg;
   assign cache_write_enable = we_comb;
   assign done               = done_reg;

endmodule

// File: doc/flash_loader.md
# flash_loader

Boot-time loader that copies a fixed region of SPI NOR flash into the cache/PSRAM path. It sits directly upstream of `Cache`: it issues a standard READ (0x03) to the flash, assembles the serial byte stream into 32-bit little-endian words, and writes each word through the cache's word-write port. When the transfer completes it releases the flash, raises `done`, and hands the cache over to the rest of the design.

## Interface
Parameters:
- `STARTUP_WAIT`, 1_000_000: clock cycles held idle after reset before the flash is selected.
- `FLASH_ADDRESS`, 24'h00_0000: first flash byte address read.
- `CACHE_ADDRESS`, 32'h0000_0000: cache byte address of the first word written.
- `TRANSFER_BYTES_NUM`, 32'h0001_0000: bytes copied. Must be a nonzero multiple of 4; violation is an elaboration `$error`.

Ports:
- `clk`  in  1  cache clock (`br_clk_out` domain).
- `rst`  in  1  **asynchronous, active-high reset.**
- `flash_clk`  out  1  SPI clock, mode 0, at most clk/2.
- `flash_mosi`  out  1  SPI data to flash.
- `flash_miso`  in  1  SPI data from flash.
- `flash_cs`  out  1  flash chip select, active low.
- `cache_address`  out  32  byte address of the word write.
- `cache_data_in`  out  32  word to write.
- `cache_write_enable`  out  4  byte enables. `4'b1111` for one cycle per word, otherwise `0`.
- `cache_busy`  in  1  cache cannot accept a command while high.
- `done`  out  1  transfer complete. Sticky until reset.

## Operation
- States: `STARTUP` → `SEND` → `READ` → `WRITE` → `WAIT_CACHE` → (`READ` | `DONE`).
- `STARTUP`: a counter runs from 0. When it reaches `STARTUP_WAIT - 1`, the block drives `flash_cs` low, loads the 32-bit shift register with {8'h03, `FLASH_ADDRESS`}, and enters `SEND`.
- `SEND`: shifts out 32 bits, MSB first. Each bit takes 2 cycles:
  - phase 0: `flash_clk` ← 0, `flash_mosi` ← bit.
  - phase 1: `flash_clk` ← 1.
  - After the 32nd rising edge, go to `READ` with the bit count cleared.
- `READ`: same 2-cycle bit timing, with `flash_mosi` held 0.
  - `flash_miso` is sampled on the cycle that drives `flash_clk` to 1 and shifted into the byte register, MSB first.
  - Each completed byte is placed little-endian: byte k of the word goes to bits [8k+7:8k], so the first flash byte lands in [7:0].
  - After 32 bits, go to `WRITE`.
- `WRITE`: entered with `flash_clk` = 1; this state drives `flash_clk` to 0. Two cases:
  - `cache_busy` low: drive `cache_address`, `cache_data_in` and `cache_write_enable` = 1111 for exactly this cycle, then go to `WAIT_CACHE`.
  - `cache_busy` high: stay in `WRITE` with `cache_write_enable` = 0.
- `WAIT_CACHE`:
  - The first cycle is an unconditional skip, to allow `cache_busy` to rise.
  - After that, wait for `cache_busy` low.
  - Then advance the address by 4. If the bytes written equal `TRANSFER_BYTES_NUM`, go to `DONE`; otherwise go to `READ`.
- During `WRITE`/`WAIT_CACHE`, `flash_clk` is held low. The flash read stream stalls and resumes without re-issuing the command.
- `DONE`: `flash_cs` = 1, `flash_clk` = 0, `done` = 1. Remains in `DONE` until reset.
- Arithmetic and wrap:
  - `cache_address` is 32-bit and wraps modulo 2^32.
  - The flash address is not tracked; the flash auto-increments it.
  - The byte counter is 32-bit.

## Timing
- Reset values: `flash_cs` = 1, `flash_clk` = 0, `flash_mosi` = 0, `cache_write_enable` = 0, `cache_address` = `CACHE_ADDRESS`, `cache_data_in` = 0, `done` = 0, state = `STARTUP`, all counters 0.
- `flash_cs` falls `STARTUP_WAIT` cycles after reset deassertion.
- Command plus address: 64 cycles. Each word read: 64 cycles.
- Word write with an idle cache: 1 cycle in `WRITE` + 1 skip + ≥1 cycle in `WAIT_CACHE`.
- Total with an idle cache: ≥ `STARTUP_WAIT` + 64 + (TRANSFER_BYTES_NUM/4)·67 cycles.
- `cache_write_enable` is never high on two consecutive cycles, and never while `cache_busy` is sampled high.
- Reset asserted mid-operation:
  - All outputs take their reset values asynchronously. `flash_cs` goes high immediately, aborting the flash command.
  - After deassertion the whole sequence restarts from `STARTUP`.
- `cache_busy` held high indefinitely: the block waits forever with `flash_cs` low and `flash_clk` low. There is no timeout.
- SPI timing is defined relative to `clk`: `flash_mosi` changes only with the falling `flash_clk`.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs at their reset values in the same cycle (asynchronous), `done` = 0.
- Command: with `STARTUP_WAIT`=4 and `FLASH_ADDRESS`=24'h123456, capture `flash_mosi` on the 32 rising `flash_clk` edges → 0x03123456. `flash_cs` falls 4 cycles after reset release.
- Data assembly: with `TRANSFER_BYTES_NUM`=8 and a flash model returning 11 22 33 44 55 66 77 88 →
  - write 0x44332211 at address 0, then 0x88776655 at address 4;
  - each write has `cache_write_enable`=1111 for 1 cycle;
  - then `done`=1 and `flash_cs`=1.
- Backpressure: hold `cache_busy` high for 20 cycles at the second `WRITE` → no enable pulse and `flash_clk` low throughout; the write occurs the cycle after `busy` drops, and the data is still 0x88776655.
- Reset mid-transfer: assert `rst` during the 2nd byte of the first word → `flash_cs` rises at once. After release, a full command plus both words repeat, with the first word again 0x44332211 at address 0.
- Base/wrap: `CACHE_ADDRESS`=32'hFFFF_FFFC, 8 bytes → writes at 0xFFFF_FFFC then 0x0000_0000, then `done`.
